// File: rtl/weight_pack_wr.sv
// Packs one 24-bit weight vector per kernel per beat into a dense byte stream of 32-bit words.
// Writes the four per-kernel weight BRAMs in lockstep through one shared address and write enable.
module weight_pack_wr #(
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int BIT_WIDTH      = 8,
    parameter int NUM_CHANNEL    = 3,
    parameter int NUM_KERNEL     = 4,
    parameter int DEPTH          = 1024
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       i_clr,
    input  logic [NUM_KERNEL*NUM_CHANNEL*BIT_WIDTH-1:0] i_dat,
    input  logic                                       i_vld,
    output logic                                       o_rdy,
    input  logic                                       i_flush,
    output logic                                       o_done,
    output logic                                       o_full,
    output logic [MEM_ADDR_WIDTH-1:0]                  o_wcnt,
    output logic [MEM_ADDR_WIDTH-1:0]                  memx_addr,
    output logic                                       memx_wren,
    output logic [MEM_DATA_WIDTH-1:0]                  mem0_idat,
    output logic [MEM_DATA_WIDTH-1:0]                  mem1_idat,
    output logic [MEM_DATA_WIDTH-1:0]                  mem2_idat,
    output logic [MEM_DATA_WIDTH-1:0]                  mem3_idat
);

    localparam int VEC_W = NUM_CHANNEL * BIT_WIDTH;
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_WORD = MEM_ADDR_WIDTH'(DEPTH - 1);

    // Phase counts how many residue bytes each kernel is holding: P0 none, P1 three, P2 two, P3 one.
    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

    phase_e                    phase_q, phase_d;
    logic [VEC_W-1:0]          res_q  [NUM_KERNEL];
    logic [VEC_W-1:0]          res_d  [NUM_KERNEL];
    logic [MEM_DATA_WIDTH-1:0] idat_q [NUM_KERNEL];
    logic [MEM_DATA_WIDTH-1:0] idat_d [NUM_KERNEL];
    logic [VEC_W-1:0]          vec    [NUM_KERNEL];
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                      wren_q, wren_d;
    logic                      done_q, done_d;
    logic                      full_q, full_d;
    logic                      pend_q, pend_d;
    logic                      accept;

    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_vec
        assign vec[k] = i_dat[VEC_W*k +: VEC_W];
    end

    assign o_rdy  = ~full_q & ~pend_q & ~rst & ~i_clr;
    assign accept = i_vld & o_rdy;

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block can infer a latch.
        phase_d = phase_q;
        res_d   = res_q;
        idat_d  = idat_q;
        wren_d  = 1'b0;
        done_d  = 1'b0;
        pend_d  = pend_q;
        full_d  = full_q;
        wcnt_d  = wcnt_q;
        // Address shows the word being written, then steps past it.
        addr_d  = addr_q + MEM_ADDR_WIDTH'(wren_q);

        if (accept) begin
            for (int k = 0; k < NUM_KERNEL; k++) begin
                unique case (phase_q)
                    PH0: res_d[k] = vec[k];
                    PH1: begin
                        idat_d[k] = {vec[k][7:0], res_q[k][23:0]};
                        res_d[k]  = {8'h00, vec[k][23:8]};
                    end
                    PH2: begin
                        idat_d[k] = {vec[k][15:0], res_q[k][15:0]};
                        res_d[k]  = {16'h0000, vec[k][23:16]};
                    end
                    PH3: begin
                        idat_d[k] = {vec[k][23:0], res_q[k][7:0]};
                        res_d[k]  = '0;
                    end
                endcase
            end
            wren_d  = (phase_q != PH0);
            phase_d = phase_e'(phase_q + 2'd1);
        end else if (pend_q) begin
            // Residue is stored right-aligned with zeroed upper bytes, so it is already padded.
            for (int k = 0; k < NUM_KERNEL; k++) begin
                idat_d[k] = (phase_q != PH0 && !full_q) ? {8'h00, res_q[k]} : idat_q[k];
                res_d[k]  = '0;
            end
            wren_d  = (phase_q != PH0) && !full_q;
            done_d  = 1'b1;
            pend_d  = 1'b0;
            phase_d = PH0;
        end

        if (i_flush && !pend_q) pend_d = 1'b1;

        if (wren_d) begin
            wcnt_d = wcnt_q + MEM_ADDR_WIDTH'(1);
            if (wcnt_q == LAST_WORD) full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst || i_clr) begin
            phase_q <= PH0;
            addr_q  <= '0;
            wcnt_q  <= '0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            pend_q  <= 1'b0;
            for (int k = 0; k < NUM_KERNEL; k++) begin
                res_q[k]  <= '0;
                idat_q[k] <= '0;
            end
        end else begin
            phase_q <= phase_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
            full_q  <= full_d;
            pend_q  <= pend_d;
            res_q   <= res_d;
            idat_q  <= idat_d;
        end
    end

    assign memx_addr = addr_q;
    assign memx_wren = wren_q;
    assign o_wcnt    = wcnt_q;
    assign o_done    = done_q;
    assign o_full    = full_q;
    assign mem0_idat = idat_q[0];
    assign mem1_idat = idat_q[1];
    assign mem2_idat = idat_q[2];
    assign mem3_idat = idat_q[3];

endmodule
